// File: rtl/ramb16_s1_s18_bitpack_ctrl.sv
// Bit-serial to 16-bit word packer using an external S1/S18 block RAM as a 16384-bit ring buffer.
// Optional macro RS1S18_LEVEL_EN adds a registered LEVEL output.
module ramb16_s1_s18_bitpack_ctrl #(
  parameter int AFULL_BITS = 16320
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FLUSH,
  input  logic        IN_BIT,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic        IN_AFULL,
  output logic [15:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [13:0] RAM_ADDRA,
  output logic        RAM_DIA,
  output logic        RAM_ENA,
  output logic        RAM_WEA,
  output logic [9:0]  RAM_ADDRB,
  output logic        RAM_ENB,
  input  logic [15:0] RAM_DOB
`ifdef RS1S18_LEVEL_EN
  ,
  output logic [14:0] LEVEL
`endif
);

  typedef enum logic {IDLE, PRESENT} state_t;

  localparam logic [15:0] AFULL_W = 16'(AFULL_BITS);

  state_t      state_q, state_d;
  logic [14:0] wptr_q, wptr_d;
  logic [10:0] rptr_q, rptr_d;
  logic        afull_q;
  logic [14:0] level, level_d;
  logic [10:0] rptr_inc;
  logic        wr, pop;

  assign level    = wptr_q - {rptr_q, 4'b0000};
  assign rptr_inc = rptr_q + 11'd1;
  assign IN_READY = (level != 15'h4000) && !FLUSH;
  // Gate with RST_N so the RAM sees no write strobe while reset is held.
  assign wr       = IN_VALID && IN_READY && RST_N;

  assign RAM_ENA   = wr;
  assign RAM_WEA   = wr;
  assign RAM_ADDRA = wptr_q[13:0];
  assign RAM_DIA   = IN_BIT;
  assign OUT_DATA  = RAM_DOB;
  assign IN_AFULL  = afull_q;

  always_comb begin
    state_d   = state_q;
    OUT_VALID = 1'b0;
    RAM_ENB   = 1'b0;
    RAM_ADDRB = rptr_q[9:0];
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (wptr_q[14:4] != rptr_q && !FLUSH) begin
          RAM_ENB = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        OUT_VALID = 1'b1;
        // Without a pop, ENB stays low so DOB keeps presenting the same word.
        if (OUT_READY && !FLUSH) begin
          pop = 1'b1;
          if (wptr_q[14:4] != rptr_inc) begin
            RAM_ENB   = 1'b1;
            RAM_ADDRB = rptr_inc[9:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (FLUSH) state_d = IDLE;
  end

  always_comb begin
    wptr_d  = FLUSH ? 15'd0 : wptr_q + {14'd0, wr};
    rptr_d  = FLUSH ? 11'd0 : rptr_q + {10'd0, pop};
    level_d = wptr_d - {rptr_d, 4'b0000};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      afull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      afull_q <= ({1'b0, level_d} >= AFULL_W);
    end
  end

`ifdef RS1S18_LEVEL_EN
  logic [14:0] level_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) level_q <= '0;
    else        level_q <= level_d;
  end
  assign LEVEL = level_q;
`endif

endmodule

// File: tb/tb_ramb16_s1_s18_bitpack_ctrl.sv
// Directed bench for the bit packer with a behavioural S1/S18 RAM model.
module tb_ramb16_s1_s18_bitpack_ctrl;
  logic        CLK, RST_N, FLUSH, IN_BIT, IN_VALID, IN_READY, IN_AFULL;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID, OUT_READY;
  logic [13:0] RAM_ADDRA;
  logic        RAM_DIA, RAM_ENA, RAM_WEA;
  logic [9:0]  RAM_ADDRB;
  logic        RAM_ENB;
  logic [15:0] RAM_DOB;
`ifdef RS1S18_LEVEL_EN
  logic [14:0] LEVEL;
`endif

  int npass = 0;
  int ntot  = 0;

  ramb16_s1_s18_bitpack_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .IN_BIT(IN_BIT), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .IN_AFULL(IN_AFULL), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .RAM_ADDRA(RAM_ADDRA), .RAM_DIA(RAM_DIA), .RAM_ENA(RAM_ENA),
    .RAM_WEA(RAM_WEA), .RAM_ADDRB(RAM_ADDRB), .RAM_ENB(RAM_ENB), .RAM_DOB(RAM_DOB)
`ifdef RS1S18_LEVEL_EN
    , .LEVEL(LEVEL)
`endif
  );

  // RAM model: 1-bit write port A, registered 16-bit read port B.
  logic mem [0:16383];
  always @(posedge CLK) begin
    if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= RAM_DIA;
    if (RAM_ENB)
      for (int n = 0; n < 16; n++) RAM_DOB[n] <= mem[{RAM_ADDRB, n[3:0]}];
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [31:0] pat;
    logic [15:0] acc;
    logic [15:0] got [0:3];
    logic [15:0] expq [$];
    logic [15:0] w;
    int nw, sent, ngot, cyc, nb;

    RST_N = 1'b0; FLUSH = 1'b0; IN_BIT = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    RAM_DOB = '0;
    #2;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_afull", IN_AFULL, 0);
    chk("rst_ena", RAM_ENA, 0);
    chk("rst_enb", RAM_ENB, 0);
    tick();
    RST_N = 1'b1;

    // single word 0x0001 and its latency
    for (int i = 0; i < 16; i++) begin
      IN_VALID = 1'b1; IN_BIT = (i == 0);
      if (i == 0) begin
        #1;
        chk("first_ena", RAM_ENA, 1);
        chk("first_addra", RAM_ADDRA, 0);
      end
      tick();
    end
    IN_VALID = 1'b0;
    #1;
    chk("lat_enb", RAM_ENB, 1);
    chk("lat_addrb", RAM_ADDRB, 0);
    chk("lat_vld_early", OUT_VALID, 0);
    tick(); #1;
    chk("lat_vld", OUT_VALID, 1);
    chk("lat_data", OUT_DATA, 32'h0001);
    OUT_READY = 1'b1;
    tick(); #1;
    OUT_READY = 1'b0;
    chk("pop_idle", OUT_VALID, 0);

    // two words streamed with OUT_READY held
    pat = {16'h1234, 16'hA5C3};
    nw = 0;
    OUT_READY = 1'b1;
    for (int c = 0; c < 40; c++) begin
      IN_VALID = (c < 32); IN_BIT = (c < 32) ? pat[c[4:0]] : 1'b0;
      #1;
      if (OUT_VALID && OUT_READY) begin
        if (nw < 4) got[nw] = OUT_DATA;
        nw++;
      end
      tick();
    end
    OUT_READY = 1'b0; IN_VALID = 1'b0;
    chk("two_count", nw, 2);
    chk("two_w0", got[0], 32'hA5C3);
    chk("two_w1", got[1], 32'h1234);

    // flush, then fill to full with OUT_READY low
    FLUSH = 1'b1;
    #1;
    chk("flush_ready", IN_READY, 0);
    tick();
    FLUSH = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      IN_VALID = 1'b1; IN_BIT = i[0];
      tick();
      if (i == 16318) chk("afull_below", IN_AFULL, 0);
      if (i == 16319) chk("afull_at", IN_AFULL, 1);
    end
    #1;
    chk("full_ready", IN_READY, 0);
    chk("full_ena", RAM_ENA, 0);
    chk("full_vld", OUT_VALID, 1);
    chk("full_data", OUT_DATA, 32'hAAAA);
`ifdef RS1S18_LEVEL_EN
    chk("full_level", LEVEL, 32'h4000);
`endif
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    #1;
    chk("pop_ready", IN_READY, 1);
    chk("pop_afull", IN_AFULL, 1);
    chk("pop_next_vld", OUT_VALID, 1);
    chk("pop_next_data", OUT_DATA, 32'hAAAA);

    // 20000 random bits, random back-pressure, across the wrap
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    sent = 0; ngot = 0; cyc = 0; nb = 0; acc = '0;
    while (ngot < 1250 && cyc < 60000) begin
      IN_VALID  = (sent < 20000);
      IN_BIT    = 1'($urandom);
      OUT_READY = 1'($urandom_range(0, 1));
      #1;
      if (IN_VALID && IN_READY) begin
        acc[nb] = IN_BIT;
        sent++;
        if (nb == 15) expq.push_back(acc);
        nb = (nb + 1) % 16;
      end
      if (OUT_VALID && OUT_READY) begin
        if (expq.size() == 0) chk("wrap_spurious", OUT_VALID, 0);
        else begin
          w = expq.pop_front();
          chk("wrap_word", OUT_DATA, w);
        end
        ngot++;
      end
      tick();
      cyc++;
    end
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    chk("wrap_count", ngot, 1250);
    chk("wrap_sent", sent, 20000);

    // partial word discarded by FLUSH
    for (int i = 0; i < 10; i++) begin
      IN_VALID = 1'b1; IN_BIT = 1'b0;
      tick();
    end
    FLUSH = 1'b1;
    #1;
    chk("flush_ready2", IN_READY, 0);
    chk("flush_ena", RAM_ENA, 0);
    tick();
    FLUSH = 1'b0;
    nw = 0;
    OUT_READY = 1'b1;
    for (int c = 0; c < 24; c++) begin
      IN_VALID = (c < 16); IN_BIT = 1'b1;
      #1;
      if (OUT_VALID && OUT_READY) begin
        if (nw < 4) got[nw] = OUT_DATA;
        nw++;
      end
      tick();
    end
    OUT_READY = 1'b0; IN_VALID = 1'b0;
    chk("flush_count", nw, 1);
    chk("flush_word", got[0], 32'hFFFF);

    // asynchronous reset while a word is presented
    for (int i = 0; i < 16; i++) begin
      IN_VALID = 1'b1; IN_BIT = (i < 8);
      tick();
    end
    IN_VALID = 1'b0;
    tick(); #1;
    chk("pre_rst_vld", OUT_VALID, 1);
    chk("pre_rst_data", OUT_DATA, 32'h00FF);
    IN_VALID = 1'b1;
    RST_N = 1'b0;
    #1;
    chk("arst_vld", OUT_VALID, 0);
    chk("arst_ena", RAM_ENA, 0);
    chk("arst_ready", IN_READY, 1);
    chk("arst_afull", IN_AFULL, 0);
`ifdef RS1S18_LEVEL_EN
    chk("arst_level", LEVEL, 0);
`endif
    tick();
    RST_N = 1'b1; IN_VALID = 1'b0;
    tick(); tick(); #1;
    chk("post_rst_vld", OUT_VALID, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
